// File: rtl/vec_collector.sv
// vec_collector
//   Serial-to-vector assembly stage. Collects NINPUTS consecutive IWIDTH-bit
//   elements from a valid/ready stream and presents them as one unpacked
//   vector on a valid/ready output. Double-buffered: the fill buffer gathers
//   the next vector while the output register holds the current one.
//
//   Optional feature macro: VEC_COLLECT_TLAST_EN
//     When defined, adds input in_last. An accepted element with in_last=1
//     closes the vector early. The unfilled tail of that vector is emitted
//     as zeros.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   in_data    element value
//   in_valid   in_data valid
//   in_last    (VEC_COLLECT_TLAST_EN only) element closes the vector
//   in_ready   block can accept an element this cycle (decoded from state only)
//   out_data   assembled vector; index i = i-th accepted element
//   out_valid  out_data holds a complete vector
//   out_ready  downstream accepts out_data this cycle
//   elem_idx   slot the next accepted element will occupy
//   vec_count  vectors loaded into the output register, wraps mod 2^CNTW
module vec_collector #(
  parameter int IWIDTH  = 10,
  parameter int NINPUTS = 8,
  parameter int CNTW    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [IWIDTH-1:0]          in_data,
  input  logic                       in_valid,
`ifdef VEC_COLLECT_TLAST_EN
  input  logic                       in_last,
`endif
  output logic                       in_ready,
  output logic [IWIDTH-1:0]          out_data [NINPUTS-1:0],
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(NINPUTS)-1:0] elem_idx,
  output logic [CNTW-1:0]            vec_count
);

  localparam int IDXW = $clog2(NINPUTS);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t            state_reg;
  logic [IWIDTH-1:0] fill_reg [NINPUTS-1:0];
  logic [IWIDTH-1:0] next_vec [NINPUTS-1:0];

  logic accept;
  logic last_flag;
  logic is_final;
  logic slot_free;
  logic load_from_in;
  logic load_from_fill;

`ifdef VEC_COLLECT_TLAST_EN
  assign last_flag = in_last;
`else
  assign last_flag = 1'b0;
`endif

  // in_ready is a pure decode of the state flop. It never looks at out_ready.
  assign in_ready  = (state_reg == FILL);
  assign accept    = in_valid && in_ready;
  assign is_final  = accept && ((elem_idx == IDXW'(NINPUTS - 1)) || last_flag);
  assign slot_free = !out_valid || out_ready;

  assign load_from_in   = (state_reg == FILL) && is_final && slot_free;
  assign load_from_fill = (state_reg == FULL) && slot_free;

  // Vector as it stands once the current element is written.
  // Slots above elem_idx are zeroed so a short (in_last) vector cannot carry
  // stale data from an earlier vector. On a normal final element elem_idx is
  // NINPUTS-1, so no slot is zeroed.
  generate
    for (genvar gi = 0; gi < NINPUTS; gi++) begin : g_next
      assign next_vec[gi] = (IDXW'(gi) == elem_idx) ? in_data :
                            (IDXW'(gi) >  elem_idx) ? '0      :
                                                      fill_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= FILL;
      elem_idx  <= '0;
      out_valid <= 1'b0;
      vec_count <= '0;
      for (int i = 0; i < NINPUTS; i++) begin
        fill_reg[i] <= '0;
        out_data[i] <= '0;
      end
    end else begin
      // Fill side
      if (accept) begin
        if (is_final) begin
          elem_idx <= '0;
          // The complete vector is captured here in both cases. It is either
          // forwarded to the output at this edge or parked for FULL.
          fill_reg <= next_vec;
          if (!slot_free) begin
            state_reg <= FULL;
          end
        end else begin
          elem_idx           <= elem_idx + IDXW'(1);
          fill_reg[elem_idx] <= in_data;
        end
      end

      if (load_from_fill) begin
        state_reg <= FILL;
      end

      // Output side. A load wins over a drain at the same edge.
      if (load_from_in || load_from_fill) begin
        out_data  <= load_from_in ? next_vec : fill_reg;
        out_valid <= 1'b1;
        vec_count <= vec_count + CNTW'(1);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vec_collector.sv
module tb_vec_collector;

  localparam int IW = 10;
  localparam int N  = 8;
  localparam int CW = 4;
  localparam int XW = $clog2(N);
`ifdef VEC_COLLECT_TLAST_EN
  localparam bit TLAST = 1'b1;
`else
  localparam bit TLAST = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [IW-1:0]  in_data = '0;
  logic           in_valid = 1'b0;
  logic           in_last = 1'b0;
  logic           in_ready;
  logic [IW-1:0]  out_data [N-1:0];
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [XW-1:0]  elem_idx;
  logic [CW-1:0]  vec_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vec_collector #(.IWIDTH(IW), .NINPUTS(N), .CNTW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
`ifdef VEC_COLLECT_TLAST_EN
    .in_last  (in_last),
`endif
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .elem_idx (elem_idx),
    .vec_count(vec_count)
  );

  logic [N*IW-1:0] dut_vec;
  always_comb begin
    dut_vec = '0;
    for (int i = 0; i < N; i++) dut_vec[i*IW +: IW] = out_data[i];
  end

  // Reference model: a partial element list, at most one completed vector
  // waiting for the output slot, and the vector currently held at the output.
  logic [IW-1:0]   part_q [$];
  logic            m_out_valid;
  logic [N*IW-1:0] m_out_vec;
  logic            m_wait_valid;
  logic [N*IW-1:0] m_wait_vec;
  int              m_count;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*IW-1:0] pad_vec();
    logic [N*IW-1:0] v;
    v = '0;
    for (int i = 0; i < part_q.size(); i++) v[i*IW +: IW] = part_q[i];
    return v;
  endfunction

  task automatic model_reset();
    part_q.delete();
    m_out_valid  = 1'b0;
    m_out_vec    = '0;
    m_wait_valid = 1'b0;
    m_wait_vec   = '0;
    m_count      = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_last   = 1'b0;
    rst       = 1'b1;
    model_reset();
    #2;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_vec_count", 128'(vec_count), 128'(0));
    chk("rst_elem_idx",  128'(elem_idx),  128'(0));
    chk("rst_in_ready",  128'(in_ready),  128'(1));
    chk("rst_out_data",  128'(dut_vec),   128'(0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle: drive inputs, advance the model, compare after the edge.
  task automatic cycle(input logic v, input logic [IW-1:0] d, input logic l, input logic ordy);
    logic accept, slot_free, load;
    logic [N*IW-1:0] vec;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = ordy;
    #1;
    chk("in_ready", 128'(in_ready), 128'(!m_wait_valid));
    accept    = v && !m_wait_valid;
    slot_free = !m_out_valid || ordy;
    load      = 1'b0;
    if (m_wait_valid && slot_free) begin
      m_out_vec    = m_wait_vec;
      m_wait_valid = 1'b0;
      load         = 1'b1;
    end else if (accept) begin
      part_q.push_back(d);
      if (part_q.size() == N || (TLAST && l)) begin
        vec = pad_vec();
        part_q.delete();
        if (slot_free) begin
          m_out_vec = vec;
          load      = 1'b1;
        end else begin
          m_wait_vec   = vec;
          m_wait_valid = 1'b1;
        end
      end
    end
    if (load) begin
      m_out_valid = 1'b1;
      m_count++;
      $display("vec %0d loaded data=%h", m_count, m_out_vec);
    end else if (m_out_valid && ordy) begin
      m_out_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("out_valid", 128'(out_valid), 128'(m_out_valid));
    chk("vec_count", 128'(vec_count), 128'(m_count % (1 << CW)));
    chk("elem_idx",  128'(elem_idx),  128'(part_q.size()));
    if (m_out_valid) chk("out_data", 128'(dut_vec), 128'(m_out_vec));
  endtask

  initial begin
    model_reset();
    do_reset();

    // Basic fill with the output slot always free
    for (int i = 1; i <= N; i++) cycle(1'b1, IW'(i), 1'b0, 1'b1);
    chk("basic_count", 128'(vec_count), 128'(1));
    chk("basic_last",  128'(out_data[N-1]), 128'(N));
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Backpressure: second vector parks in the fill buffer, 17 is refused
    do_reset();
    for (int i = 1; i <= 2*N; i++) cycle(1'b1, IW'(i), 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b1, IW'(2*N+1), 1'b0, 1'b0);
    chk("bp_held_first", 128'(out_data[0]), 128'(1));
    cycle(1'b1, IW'(2*N+1), 1'b0, 1'b1);
    chk("bp_second_first", 128'(out_data[0]), 128'(N+1));
    chk("bp_count", 128'(vec_count), 128'(2));
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Streaming: 24 elements back-to-back
    do_reset();
    for (int i = 0; i < 3*N; i++) cycle(1'b1, IW'(i), 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Reset mid-vector
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, IW'(100+i), 1'b0, 1'b1);
    do_reset();
    for (int i = 1; i <= N; i++) cycle(1'b1, IW'(i), 1'b0, 1'b1);
    chk("midrst_count", 128'(vec_count), 128'(1));
    chk("midrst_elem5", 128'(out_data[5]), 128'(6));

    // Counter wrap: 17 vectors with a 4-bit counter
    do_reset();
    for (int i = 0; i < 17*N; i++) cycle(1'b1, IW'(i), 1'b0, 1'b1);
    chk("wrap_count", 128'(vec_count), 128'(1));

`ifdef VEC_COLLECT_TLAST_EN
    // Short vector after a full vector of 0xFF: tail must be zero
    do_reset();
    for (int i = 0; i < N; i++) cycle(1'b1, IW'(8'hFF), 1'b0, 1'b1);
    cycle(1'b1, IW'(7), 1'b0, 1'b1);
    cycle(1'b1, IW'(8), 1'b0, 1'b1);
    cycle(1'b1, IW'(9), 1'b1, 1'b1);
    chk("tlast_e2",  128'(out_data[2]), 128'(9));
    chk("tlast_e3",  128'(out_data[3]), 128'(0));
    chk("tlast_e7",  128'(out_data[N-1]), 128'(0));
    chk("tlast_idx", 128'(elem_idx), 128'(0));
`endif

    // Random traffic against the model
    do_reset();
    for (int k = 0; k < 800; k++) begin
      cycle($urandom_range(0, 3) != 0, IW'($urandom), TLAST && ($urandom_range(0, 5) == 0),
            $urandom_range(0, 1) == 1);
    end
    for (int k = 0; k < 4; k++) cycle(1'b0, '0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
